mmio_io_ctrl: RTL

Memory-mapped I/O controller in the CPU's MEM stage. It decodes loads and stores whose address is in the I/O region (addr[31:28] == 4'h8) and connects them to the on-chip UART's ready/valid ports. It also owns the cycle and retired-instruction counters. Load data returns one cycle after the request, with the same latency as dmem/bios reads, so the writeback select mux treats it like a memory read.

---
 rtl/mmio_io_ctrl_pkg.sv | 22 ++
 rtl/mmio_io_ctrl_if.sv | 25 ++
 rtl/mmio_io_ctrl_counter.sv | 25 ++
 rtl/mmio_io_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/mmio_io_ctrl_pkg.sv
// Shared constants for the MEM-stage I/O controller: region select, register
// word indices and the TX holding-register state encoding.
package mmio_pkg;

  localparam logic [3:0] IO_NIBBLE = 4'h8;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_RXDATA = 6'h01;
  localparam logic [5:0] ADDR_TXDATA = 6'h02;
  localparam logic [5:0] ADDR_CYCLES = 6'h04;
  localparam logic [5:0] ADDR_INSTRS = 6'h05;
  localparam logic [5:0] ADDR_CNTRST = 6'h06;

  localparam logic [0:0] TX_EMPTY = 1'b0;
  localparam logic [0:0] TX_FULL  = 1'b1;

  // Word index inside the I/O region; byte lane bits are ignored.
  function automatic logic [5:0] reg_idx(input logic [31:0] addr);
    return addr[7:2];
  endfunction

endpackage

// File: rtl/mmio_io_ctrl_if.sv
// CPU-side load/store bus plus the UART ready/valid ports of the I/O controller.
interface mmio_io_ctrl_if;
  logic [31:0] addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        io_hit;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  modport master (
    output addr, re, we, din, uart_tx_ready, uart_rx_data, uart_rx_valid,
    input  dout, io_hit, uart_tx_data, uart_tx_valid, uart_rx_ready
  );

  modport slave (
    input  addr, re, we, din, uart_tx_ready, uart_rx_data, uart_rx_valid,
    output dout, io_hit, uart_tx_data, uart_tx_valid, uart_rx_ready
  );
endinterface

// File: rtl/mmio_io_ctrl_counter.sv
// Free-running wrap-around counter with enable and synchronous clear.
module io_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_reg;

  // Clear beats a same-cycle increment so a CNTRST store always reads back 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign q = cnt_reg;

endmodule

// File: rtl/mmio_io_ctrl.sv
// MEM-stage memory-mapped I/O: UART TX/RX ports plus cycle and retired-instruction
// counters, with one-cycle registered load data like dmem/bios.
module mmio_io_ctrl
  import mmio_pkg::*;
#(
  parameter logic [3:0] IO_NIBBLE = mmio_pkg::IO_NIBBLE,
  parameter int          CNT_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inst_retire,
  mmio_io_ctrl_if.slave  bus
);

  logic [5:0]  idx;
  logic        rd_req;
  logic        wr_req;
  logic        tx_store;
  logic        tx_drain;
  logic        cnt_clr;
  logic [31:0] rd_data;
  logic [31:0] dout_reg;
  logic [0:0]  tx_state_reg, tx_state_next;
  logic [7:0]  tx_data_reg, tx_data_next;

  logic [CNT_WIDTH-1:0] cnt_q   [2];
  logic                 cnt_en  [2];
  logic [31:0]          cnt_ext [2];

  logic unused_bits;
  assign unused_bits = ^{bus.addr[27:8], bus.addr[1:0], bus.din[31:8]};

  assign idx        = reg_idx(bus.addr);
  assign bus.io_hit = (bus.addr[31:28] == IO_NIBBLE);
  assign rd_req     = bus.re && bus.io_hit;
  assign wr_req     = (|bus.we) && bus.io_hit;
  assign tx_store   = wr_req && (idx == ADDR_TXDATA) && bus.we[0];
  assign tx_drain   = (tx_state_reg == TX_FULL) && bus.uart_tx_ready;
  assign cnt_clr    = wr_req && (idx == ADDR_CNTRST);

  // Pop only when there is something to pop; the data is sampled this same cycle.
  assign bus.uart_rx_ready = rd_req && (idx == ADDR_RXDATA) && bus.uart_rx_valid;

  // Index 0 counts cycles, index 1 counts retired instructions.
  assign cnt_en[0] = 1'b1;
  assign cnt_en[1] = inst_retire;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      io_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en[gi]),
        .q   (cnt_q[gi])
      );
      assign cnt_ext[gi] = 32'(cnt_q[gi]);
    end
  endgenerate

  always_comb begin
    rd_data = 32'h0;
    case (idx)
      ADDR_CTRL:   rd_data = {30'b0, bus.uart_rx_valid, tx_state_reg == TX_EMPTY};
      ADDR_RXDATA: rd_data = {24'b0, bus.uart_rx_data};
      ADDR_CYCLES: rd_data = cnt_ext[0];
      ADDR_INSTRS: rd_data = cnt_ext[1];
      default:     rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_reg <= 32'h0;
    end else if (rd_req) begin
      dout_reg <= rd_data;
    end
  end

  // A store is accepted when the slot is empty or is being drained this cycle.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_data_next  = tx_data_reg;
    if (tx_store && (tx_state_reg == TX_EMPTY || tx_drain)) begin
      tx_state_next = TX_FULL;
      tx_data_next  = bus.din[7:0];
    end else if (tx_drain) begin
      tx_state_next = TX_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= TX_EMPTY;
      tx_data_reg  <= 8'h0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_data_reg  <= tx_data_next;
    end
  end

  assign bus.dout          = dout_reg;
  assign bus.uart_tx_data  = tx_data_reg;
  assign bus.uart_tx_valid = (tx_state_reg == TX_FULL);

endmodule
